i2c_snoop: RTL and testbench

- Passive, non-driving sniffer on an I2C bus (SoC↔PMIC main bus or private bus). Emits each 9-bit transfer slot (8 data bits plus the ACK bit) as a word with a one-cycle ready strobe.
- Sits directly upstream of the PMIC-substitution core. One instance per bus. Outputs feed that core's 9-bit bus inputs and its ready inputs.
- Output word format: bits [8:1] are the data byte (MSB first on the wire), bit 0 is the ACK bit (0 = ACK).

---
 rtl/i2c_snoop_pkg.sv | 13 +
 rtl/i2c_line_sync.sv | 47 ++++
 rtl/i2c_snoop.sv | 132 +++++++++++++
 tb/tb_i2c_snoop.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_snoop_pkg.sv
// Shared definitions for the passive I2C bus sniffer: FSM encoding and word layout.
package i2c_snoop_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int   WORD_W    = 9;
    localparam int   ACK_BIT   = 0;
    localparam logic ACK_LEVEL = 1'b0;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchroniser for one raw I2C line, with an optional glitch filter
// (enabled by I2C_SNOOP_GLITCH_FILTER_EN). Idle level after reset is 1.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || FILT_LEN < 1 || FILT_LEN > 15) begin : g_bad_param
        $error("i2c_line_sync: illegal SYNC_STAGES or FILT_LEN");
    end

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) sync_q <= '1;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end

`ifdef I2C_SNOOP_GLITCH_FILTER_EN
    localparam logic [3:0] RELOAD = 4'(FILT_LEN - 1);

    logic [3:0] cnt;

    // Down-counter runs while the synchronised sample differs from the accepted level.
    always_ff @(posedge clk) begin
        if (reset) begin
            level <= 1'b1;
            cnt   <= RELOAD;
        end else if (sync_q[SYNC_STAGES-1] == level) begin
            cnt   <= RELOAD;
        end else if (cnt == 4'd0) begin
            level <= sync_q[SYNC_STAGES-1];
            cnt   <= RELOAD;
        end else begin
            cnt   <= cnt - 4'd1;
        end
    end
`else
    assign level = sync_q[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/i2c_snoop.sv
// Passive I2C sniffer: emits each 9-bit slot {data, ack} with a one-cycle strobe.
// Optional line glitch filter: define I2C_SNOOP_GLITCH_FILTER_EN.
//
//   state | meaning
//   IDLE  | bus not in a transaction, waiting for START
//   SHIFT | between START and STOP, collecting slot bits
module i2c_snoop
    import i2c_snoop_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              scl_in,
    input  logic              sda_in,
    output logic [WORD_W-1:0] word,
    output logic              word_ready,
    output logic              first_byte,
    output logic              start_seen,
    output logic              stop_seen,
    output logic              abort_pulse,
    output logic              busy
);

    logic scl_s, sda_s, prev_scl, prev_sda;
    logic rise, start_ev, stop_ev;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_scl_sync (
        .clk(clk), .reset(reset), .raw(scl_in), .level(scl_s)
    );

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_sda_sync (
        .clk(clk), .reset(reset), .raw(sda_in), .level(sda_s)
    );

    assign rise     = !prev_scl & scl_s;
    assign start_ev = prev_scl & scl_s & prev_sda & !sda_s;
    assign stop_ev  = prev_scl & scl_s & !prev_sda & sda_s;

    state_t            state, state_nxt;
    logic [3:0]        bitcnt, bitcnt_nxt;
    logic [7:0]        shreg, shreg_nxt;
    logic              first_flag, first_flag_nxt;
    logic [WORD_W-1:0] word_nxt;
    logic              word_ready_nxt, first_byte_nxt, start_nxt, stop_nxt, abort_nxt, busy_nxt;

    always_comb begin
        state_nxt      = state;
        bitcnt_nxt     = bitcnt;
        shreg_nxt      = shreg;
        first_flag_nxt = first_flag;
        word_nxt       = word;
        busy_nxt       = busy;
        word_ready_nxt = 1'b0;
        first_byte_nxt = 1'b0;
        start_nxt      = 1'b0;
        stop_nxt       = 1'b0;
        abort_nxt      = 1'b0;

        case (state)
            IDLE: begin
                if (start_ev) begin
                    state_nxt      = SHIFT;
                    start_nxt      = 1'b1;
                    busy_nxt       = 1'b1;
                    bitcnt_nxt     = 4'd0;
                    first_flag_nxt = 1'b1;
                end
            end
            SHIFT: begin
                if (rise) begin
                    shreg_nxt = {shreg[6:0], sda_s};
                    if (bitcnt == 4'd8) begin
                        word_nxt       = {shreg, sda_s};
                        word_ready_nxt = 1'b1;
                        first_byte_nxt = first_flag;
                        first_flag_nxt = 1'b0;
                        bitcnt_nxt     = 4'd0;
                    end else begin
                        bitcnt_nxt     = bitcnt + 4'd1;
                    end
                end else if (start_ev) begin
                    start_nxt      = 1'b1;
                    abort_nxt      = (bitcnt != 4'd0);
                    bitcnt_nxt     = 4'd0;
                    first_flag_nxt = 1'b1;
                end else if (stop_ev) begin
                    stop_nxt   = 1'b1;
                    busy_nxt   = 1'b0;
                    abort_nxt  = (bitcnt != 4'd0);
                    bitcnt_nxt = 4'd0;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_scl    <= 1'b1;
            prev_sda    <= 1'b1;
            state       <= IDLE;
            bitcnt      <= 4'd0;
            shreg       <= 8'd0;
            first_flag  <= 1'b0;
            word        <= '0;
            word_ready  <= 1'b0;
            first_byte  <= 1'b0;
            start_seen  <= 1'b0;
            stop_seen   <= 1'b0;
            abort_pulse <= 1'b0;
            busy        <= 1'b0;
        end else begin
            prev_scl    <= scl_s;
            prev_sda    <= sda_s;
            state       <= state_nxt;
            bitcnt      <= bitcnt_nxt;
            shreg       <= shreg_nxt;
            first_flag  <= first_flag_nxt;
            word        <= word_nxt;
            word_ready  <= word_ready_nxt;
            first_byte  <= first_byte_nxt;
            start_seen  <= start_nxt;
            stop_seen   <= stop_nxt;
            abort_pulse <= abort_nxt;
            busy        <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_i2c_snoop.sv
// Randomised bench for i2c_snoop: bus waveforms are built as level segments and
// decoded by a protocol-level model; observed event streams are compared in order.
module tb_i2c_snoop;

    localparam int SYNC_STAGES = 2;
    localparam int FILT_LEN    = 3;
    localparam int EV_START    = 1000;
    localparam int EV_STOP     = 1001;
    localparam int EV_ABORT    = 1002;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl_in = 1'b1;
    logic       sda_in = 1'b1;
    logic [8:0] word;
    logic       word_ready, first_byte, start_seen, stop_seen, abort_pulse, busy;

    i2c_snoop #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) dut (
        .clk(clk), .reset(reset), .scl_in(scl_in), .sda_in(sda_in),
        .word(word), .word_ready(word_ready), .first_byte(first_byte),
        .start_seen(start_seen), .stop_seen(stop_seen),
        .abort_pulse(abort_pulse), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit scl;
        bit sda;
        int len;
    } seg_t;

    seg_t segs[$];
    int   exp_q[$];
    int   obs_q[$];
    int   checks = 0;
    int   failures = 0;

    // protocol model state
    bit   m_busy = 0;
    bit   m_first = 0;
    bit   m_bits[$];
    bit   m_prev_scl = 1;
    bit   m_prev_sda = 1;

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (abort_pulse) obs_q.push_back(EV_ABORT);
            if (stop_seen)   obs_q.push_back(EV_STOP);
            if (start_seen)  obs_q.push_back(EV_START);
            if (word_ready)  obs_q.push_back((first_byte ? 512 : 0) + int'(word));
        end
    end

    function automatic int rlen();
        return int'($urandom_range(4, 7));
    endfunction

    function automatic void add_seg(input bit scl, input bit sda, input int len);
        seg_t s;
        s.scl = scl; s.sda = sda; s.len = len;
        segs.push_back(s);
    endfunction

    function automatic void add_start();
        add_seg(0, 1, rlen()); add_seg(1, 1, rlen());
        add_seg(1, 0, rlen()); add_seg(0, 0, rlen());
    endfunction

    function automatic void add_stop();
        add_seg(0, 0, rlen()); add_seg(1, 0, rlen()); add_seg(1, 1, rlen());
    endfunction

    function automatic void add_bit(input bit b, input bit glitch);
        add_seg(0, b, rlen());
        add_seg(1, b, rlen());
        if (glitch) begin
            add_seg(0, b, 2);
            add_seg(1, b, rlen());
        end
        add_seg(0, b, rlen());
    endfunction

    function automatic void add_byte(input logic [7:0] data, input bit ack, input int glitch_at);
        for (int i = 7; i >= 0; i--) add_bit(data[i], glitch_at == 7 - i);
        add_bit(ack, glitch_at == 8);
    endfunction

    function automatic void model_reset();
        m_busy = 0; m_first = 0; m_bits.delete();
        m_prev_scl = 1; m_prev_sda = 1;
    endfunction

    // Decode level segments according to I2C rules into the expected event stream.
    function automatic void model_segs();
        int w;
        foreach (segs[i]) begin
`ifdef I2C_SNOOP_GLITCH_FILTER_EN
            if (segs[i].len < FILT_LEN) continue;
`endif
            if (segs[i].scl && !m_prev_scl) begin
                if (m_busy) begin
                    m_bits.push_back(segs[i].sda);
                    if (m_bits.size() == 9) begin
                        w = 0;
                        foreach (m_bits[k]) w = (w << 1) | int'(m_bits[k]);
                        exp_q.push_back((m_first ? 512 : 0) + w);
                        m_first = 0;
                        m_bits.delete();
                    end
                end
            end else if (segs[i].scl && m_prev_scl && m_prev_sda && !segs[i].sda) begin
                if (m_busy && m_bits.size() != 0) exp_q.push_back(EV_ABORT);
                exp_q.push_back(EV_START);
                m_busy = 1; m_first = 1; m_bits.delete();
            end else if (segs[i].scl && m_prev_scl && !m_prev_sda && segs[i].sda) begin
                if (m_busy) begin
                    if (m_bits.size() != 0) exp_q.push_back(EV_ABORT);
                    exp_q.push_back(EV_STOP);
                    m_busy = 0; m_bits.delete();
                end
            end
            m_prev_scl = segs[i].scl;
            m_prev_sda = segs[i].sda;
        end
    endfunction

    task automatic run_segs();
        model_segs();
        foreach (segs[i]) begin
            scl_in = segs[i].scl;
            sda_in = segs[i].sda;
            repeat (segs[i].len) @(posedge clk);
            #1;
        end
        repeat (SYNC_STAGES + FILT_LEN + 6) @(posedge clk);
        #1;
        segs.delete();
    endtask

    task automatic compare(input string tag);
        int n;
        check_val({tag, "_count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check_val({tag, "_event"}, obs_q[i], exp_q[i]);
        check_val({tag, "_busy"}, int'(busy), int'(m_busy));
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb, k, g;
        logic [7:0] d;

        repeat (5) @(posedge clk);
        #1;
        check_val("rst_word", int'(word), 0);
        check_val("rst_ready", int'(word_ready), 0);
        check_val("rst_start", int'(start_seen), 0);
        check_val("rst_stop", int'(stop_seen), 0);
        check_val("rst_abort", int'(abort_pulse), 0);
        check_val("rst_busy", int'(busy), 0);
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // single address byte
        add_start(); add_byte(8'h94, 0, -1); add_stop();
        run_segs(); compare("t1");

        // two bytes, second NACKed
        add_start(); add_byte(8'h94, 0, -1); add_byte(8'h30, 1, -1); add_stop();
        run_segs(); compare("t2");

        // partial slot then repeated START
        add_start();
        add_bit(1, 0); add_bit(0, 0); add_bit(0, 0); add_bit(1, 0);
        add_start(); add_byte(8'h95, 0, -1);
        run_segs(); compare("t3");

        // STOP immediately followed by START while SCL stays high
        add_stop(); add_seg(1, 0, rlen()); add_seg(0, 0, rlen());
        run_segs(); compare("t4");
        add_stop();
        run_segs(); compare("t4b");

        // short SCL low glitch during a data bit
        add_start(); add_byte(8'h94, 0, 2); add_stop();
        run_segs(); compare("t5");

        // reset in the middle of a byte
        add_start();
        add_bit(1, 0); add_bit(0, 0); add_bit(0, 0); add_bit(1, 0); add_bit(0, 0);
        run_segs(); compare("t6a");
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        model_reset();
        reset = 1'b0;
        check_val("t6_rst_busy", int'(busy), 0);
        check_val("t6_rst_word", int'(word), 0);
        add_bit(1, 0); add_bit(0, 0); add_bit(0, 0); add_bit(0, 0); add_stop();
        run_segs(); compare("t6b");
        add_start(); add_byte(8'h94, 0, -1); add_stop();
        run_segs(); compare("t6c");

        // random transactions
        for (int t = 0; t < 12; t++) begin
            add_start();
            nb = int'($urandom_range(1, 3));
            for (int b = 0; b < nb; b++) begin
                if ($urandom_range(0, 4) == 0) begin
                    k = int'($urandom_range(1, 8));
                    for (int j = 0; j < k; j++) add_bit(1'($urandom), 0);
                    add_start();
                end
                d = 8'($urandom);
                g = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8)) : -1;
                add_byte(d, 1'($urandom), g);
            end
            if ($urandom_range(0, 3) == 0) begin
                k = int'($urandom_range(1, 8));
                for (int j = 0; j < k; j++) add_bit(1'($urandom), 0);
            end
            add_stop();
            run_segs(); compare("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
